alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 32-bit ALU between two requesters, e.g. the execute stage and a multi-cycle address/compare unit. Each requester issues an operation over a valid/ready handshake. The block latches the operands, drives the ALU's combinational ports for exactly one cycle, registers the result and zero flag, and returns them to the owning requester over a valid/ready response channel. At most one operation is in flight.

---
 rtl/alu_arbiter_if.sv | 39 +++
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bundle for alu_arbiter.
// The arbiter uses the slave view; requesters and the ALU use the master view.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       reqValid;
    logic [1:0]       reqReady;
    logic [WIDTH-1:0] reqOperandA0;
    logic [WIDTH-1:0] reqOperandB0;
    logic [2:0]       reqControl0;
    logic [WIDTH-1:0] reqOperandA1;
    logic [WIDTH-1:0] reqOperandB1;
    logic [2:0]       reqControl1;
    logic [1:0]       respValid;
    logic [1:0]       respReady;
    logic [WIDTH-1:0] respResult;
    logic             respZero;
    logic [WIDTH-1:0] aluOperandA;
    logic [WIDTH-1:0] aluOperandB;
    logic [2:0]       aluControl;
    logic [WIDTH-1:0] aluResult;
    logic             aluZero;

    modport slave (
        input  reqValid, reqOperandA0, reqOperandB0, reqControl0,
               reqOperandA1, reqOperandB1, reqControl1,
               respReady, aluResult, aluZero,
        output reqReady, respValid, respResult, respZero,
               aluOperandA, aluOperandB, aluControl
    );

    modport master (
        output reqValid, reqOperandA0, reqOperandB0, reqControl0,
               reqOperandA1, reqOperandB1, reqControl1,
               respReady, aluResult, aluZero,
        input  reqReady, respValid, respResult, respZero,
               aluOperandA, aluOperandB, aluControl
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (drive ALU) -> RESP (hand back).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             owner;
    logic             winner;
    logic             grant;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] result;
    logic             zero;

    // Winner selection: a lone requester wins outright, contention goes to the pointer.
    always_comb begin
        winner = ptr;
        case (bus.reqValid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ptr;
        endcase
        grant = (state == IDLE) && (|bus.reqValid);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (bus.respReady[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch on grant, result capture in EXEC; pointer moves to the loser on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            ctrl   <= '0;
            owner  <= 1'b0;
            ptr    <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            if (grant) begin
                opa   <= winner ? bus.reqOperandA1 : bus.reqOperandA0;
                opb   <= winner ? bus.reqOperandB1 : bus.reqOperandB0;
                ctrl  <= winner ? bus.reqControl1  : bus.reqControl0;
                owner <= winner;
                ptr   <= ~winner;
            end
            if (state == EXEC) begin
                result <= bus.aluResult;
                zero   <= bus.aluZero;
            end
        end
    end

    // Outputs: handshakes decoded from state; ALU ports always show the latched operation.
    always_comb begin
        bus.reqReady    = '0;
        bus.respValid   = '0;
        if (grant) begin
            bus.reqReady = winner ? 2'b10 : 2'b01;
        end
        if (state == RESP) begin
            bus.respValid = owner ? 2'b10 : 2'b01;
        end
        bus.aluOperandA = opa;
        bus.aluOperandB = opb;
        bus.aluControl  = ctrl;
        bus.respResult  = result;
        bus.respZero    = zero;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: add, sub, and, or, xor, slt, sltu, 111 -> 0.
    always_comb begin
        case (bus.aluControl)
            3'b000:  bus.aluResult = bus.aluOperandA + bus.aluOperandB;
            3'b001:  bus.aluResult = bus.aluOperandA - bus.aluOperandB;
            3'b010:  bus.aluResult = bus.aluOperandA & bus.aluOperandB;
            3'b011:  bus.aluResult = bus.aluOperandA | bus.aluOperandB;
            3'b100:  bus.aluResult = bus.aluOperandA ^ bus.aluOperandB;
            3'b101:  bus.aluResult = {31'd0, $signed(bus.aluOperandA) < $signed(bus.aluOperandB)};
            3'b110:  bus.aluResult = {31'd0, bus.aluOperandA < bus.aluOperandB};
            default: bus.aluResult = 32'd0;
        endcase
        bus.aluZero = (bus.aluResult == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        bus.reqOperandA0 = a;
        bus.reqOperandB0 = b;
        bus.reqControl0  = c;
    endtask

    task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        bus.reqOperandA1 = a;
        bus.reqOperandB1 = b;
        bus.reqControl1  = c;
    endtask

    initial begin
        logic [31:0] lone_exp [3];
        logic [2:0]  lone_ctl [3];
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.reqValid  = 2'b00;
        bus.respReady = 2'b00;
        set_req0(32'd0, 32'd0, 3'd0);
        set_req1(32'd0, 32'd0, 3'd0);
        tick();
        tick();

        // Reset values
        check("rst_reqReady",  bus.reqReady, 2'b00);
        check("rst_respValid", bus.respValid, 2'b00);
        check("rst_result",    bus.respResult, 32'd0);
        check("rst_zero",      bus.respZero, 1'b0);
        check("rst_aluA",      bus.aluOperandA, 32'd0);
        check("rst_aluB",      bus.aluOperandB, 32'd0);
        check("rst_aluCtl",    bus.aluControl, 3'd0);
        rst = 1'b0;
        tick();

        // Single add from requester 0
        set_req0(32'd5, 32'd7, 3'b000);
        bus.reqValid  = 2'b01;
        bus.respReady = 2'b11;
        #1;
        check("add_reqReady", bus.reqReady, 2'b01);
        tick();
        bus.reqValid = 2'b00;
        #1;
        check("add_exec_ready", bus.reqReady, 2'b00);
        check("add_exec_A",     bus.aluOperandA, 32'd5);
        check("add_exec_B",     bus.aluOperandB, 32'd7);
        check("add_exec_ctl",   bus.aluControl, 3'b000);
        check("add_exec_valid", bus.respValid, 2'b00);
        tick();
        check("add_resp_valid",  bus.respValid, 2'b01);
        check("add_resp_result", bus.respResult, 32'd12);
        check("add_resp_zero",   bus.respZero, 1'b0);
        tick();
        check("add_idle_valid", bus.respValid, 2'b00);
        check("add_hold_aluA",  bus.aluOperandA, 32'd5);

        // Zero flag through subtract from requester 1
        set_req1(32'd3, 32'd3, 3'b001);
        bus.reqValid = 2'b10;
        #1;
        check("sub_reqReady", bus.reqReady, 2'b10);
        tick();
        bus.reqValid = 2'b00;
        tick();
        check("sub_resp_valid",  bus.respValid, 2'b10);
        check("sub_resp_result", bus.respResult, 32'd0);
        check("sub_resp_zero",   bus.respZero, 1'b1);
        tick();

        // Contention from reset: grants alternate 0,1,0,1 every 3 cycles
        do_reset();
        set_req0(32'hFFFF_FFFF, 32'd1, 3'b101);
        set_req1(32'hFFFF_FFFF, 32'd1, 3'b110);
        bus.reqValid  = 2'b11;
        bus.respReady = 2'b11;
        #1;
        for (int c = 0; c < 12; c++) begin
            logic own1;
            own1 = ((c / 3) % 2) == 1;
            if (c % 3 == 0) begin
                check("cont_grant", bus.reqReady, own1 ? 2'b10 : 2'b01);
            end else begin
                check("cont_nogrant", bus.reqReady, 2'b00);
            end
            if (c % 3 == 1) begin
                check("cont_ctl", bus.aluControl, own1 ? 3'b110 : 3'b101);
            end
            if (c % 3 == 2) begin
                check("cont_valid",  bus.respValid, own1 ? 2'b10 : 2'b01);
                check("cont_result", bus.respResult, own1 ? 32'd0 : 32'd1);
                check("cont_zero",   bus.respZero, own1 ? 1'b1 : 1'b0);
            end
            tick();
        end
        bus.reqValid = 2'b00;

        // Back-pressure on requester 0 with requester 1 pending
        do_reset();
        set_req0(32'd10, 32'd20, 3'b000);
        bus.reqValid  = 2'b01;
        bus.respReady = 2'b00;
        #1;
        check("bp_grant0", bus.reqReady, 2'b01);
        tick();
        set_req1(32'd9, 32'd4, 3'b001);
        bus.reqValid  = 2'b10;
        bus.respReady = 2'b10;
        #1;
        check("bp_exec_noready", bus.reqReady, 2'b00);
        check("bp_exec_A",       bus.aluOperandA, 32'd10);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_stall_valid",  bus.respValid, 2'b01);
            check("bp_stall_result", bus.respResult, 32'd30);
            check("bp_stall_zero",   bus.respZero, 1'b0);
            check("bp_stall_ready",  bus.reqReady, 2'b00);
            tick();
        end
        bus.respReady = 2'b01;
        #1;
        check("bp_last_valid",  bus.respValid, 2'b01);
        check("bp_last_result", bus.respResult, 32'd30);
        check("bp_last_ready",  bus.reqReady, 2'b00);
        tick();
        check("bp_idle_grant1", bus.reqReady, 2'b10);
        check("bp_idle_valid",  bus.respValid, 2'b00);
        check("bp_idle_hold",   bus.respResult, 32'd30);
        tick();
        bus.reqValid = 2'b00;
        check("bp_exec1_A", bus.aluOperandA, 32'd9);
        tick();
        check("bp_resp1_valid",  bus.respValid, 2'b10);
        check("bp_resp1_result", bus.respResult, 32'd5);
        bus.respReady = 2'b11;
        tick();

        // Reset while in EXEC
        set_req0(32'd1, 32'd2, 3'b000);
        bus.reqValid = 2'b01;
        tick();
        bus.reqValid = 2'b00;
        #1;
        check("mid_exec_A", bus.aluOperandA, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_aluA",   bus.aluOperandA, 32'd0);
        check("mid_rst_aluB",   bus.aluOperandB, 32'd0);
        check("mid_rst_ctl",    bus.aluControl, 3'd0);
        check("mid_rst_valid",  bus.respValid, 2'b00);
        check("mid_rst_result", bus.respResult, 32'd0);
        check("mid_rst_zero",   bus.respZero, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mid_no_resp", bus.respValid, 2'b00);
            tick();
        end
        set_req0(32'd100, 32'd1, 3'b001);
        set_req1(32'd7, 32'd7, 3'b000);
        bus.reqValid = 2'b11;
        #1;
        check("mid_ptr0_grant", bus.reqReady, 2'b01);
        tick();
        bus.reqValid = 2'b00;
        tick();
        check("mid_resp_valid",  bus.respValid, 2'b01);
        check("mid_resp_result", bus.respResult, 32'd99);
        tick();

        // Lone requester 1, three back-to-back operations
        lone_ctl[0] = 3'b011; lone_exp[0] = 32'h0000_00FC;
        lone_ctl[1] = 3'b010; lone_exp[1] = 32'h0000_0030;
        lone_ctl[2] = 3'b100; lone_exp[2] = 32'h0000_00CC;
        set_req1(32'hF0, 32'h3C, lone_ctl[0]);
        bus.reqValid = 2'b10;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("lone_grant", bus.reqReady, 2'b10);
            tick();
            check("lone_exec_ctl", bus.aluControl, lone_ctl[k]);
            if (k < 2) begin
                set_req1(32'hF0, 32'h3C, lone_ctl[k+1]);
            end else begin
                bus.reqValid = 2'b00;
            end
            #1;
            check("lone_exec_ready", bus.reqReady, 2'b00);
            tick();
            check("lone_valid",    bus.respValid, 2'b10);
            check("lone_result",   bus.respResult, lone_exp[k]);
            check("lone_hold_ctl", bus.aluControl, lone_ctl[k]);
            tick();
        end
        check("lone_done_valid", bus.respValid, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
